// File: rtl/infer_mon_pkg.sv
// Shared types and default address map for the inference monitor.
//   state_e          : monitor FSM states
//   *_ADDR_DEF       : default byte addresses of the snooped memory map
package infer_mon_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] OUTPUT_ADDR_DEF = 32'h0000_0100;
    localparam logic [ADDR_W-1:0] LABEL_ADDR_DEF  = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] DONE_ADDR_DEF   = 32'h0000_0300;

endpackage

// File: rtl/infer_monitor_if.sv
// Data-memory bus bundle observed by the inference monitor.
//   req/ready : handshake, a transfer completes when both are high
//   write     : 1 = write, 0 = read
//   addr      : byte address
//   wdata     : write data
//   rdata     : read data, valid in the handshake cycle
interface infer_monitor_if #(
    parameter int unsigned DWidth = 32
);
    logic              req;
    logic              ready;
    logic              write;
    logic [DWidth-1:0] addr;
    logic [DWidth-1:0] wdata;
    logic [DWidth-1:0] rdata;

    modport master  (output req, write, addr, wdata, input  ready, rdata);
    modport slave   (input  req, write, addr, wdata, output ready, rdata);
    modport monitor (input  req, ready, write, addr, wdata, rdata);
endinterface

// File: rtl/infer_argmax.sv
// Running signed argmax over one test's output vector.
//   clk_i, rst_i : clock, synchronous active-high reset
//   valid_i      : accepted output write this cycle
//   idx_i        : class index of the write
//   data_i       : signed class score
//   clear_i      : start a new test; a same-cycle write lands after the clear
//   max_idx_o    : index of the current maximum
//   full_o       : every class written at least once
module infer_argmax #(
    parameter int unsigned DWidth     = 32,
    parameter int unsigned NumClasses = 10,
    localparam int unsigned IdxW      = $clog2(NumClasses)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [IdxW-1:0]          idx_i,
    input  logic signed [DWidth-1:0] data_i,
    input  logic                     clear_i,
    output logic [IdxW-1:0]          max_idx_o,
    output logic                     full_o
);
    logic [NumClasses-1:0]    r_mask;
    logic signed [DWidth-1:0] r_max;
    logic [IdxW-1:0]          r_idx;
    logic                     r_full;

    logic [NumClasses-1:0]    w_mask_base;
    logic [NumClasses-1:0]    w_mask_nxt;
    logic signed [DWidth-1:0] w_max_base;
    logic [IdxW-1:0]          w_idx_base;
    logic                     w_load;

    // A repeated index only touches the mask, so a stored max never drops.
    always_comb begin
        w_mask_base = clear_i ? '0 : r_mask;
        w_max_base  = clear_i ? '0 : r_max;
        w_idx_base  = clear_i ? '0 : r_idx;
        w_load      = 1'b0;
        w_mask_nxt  = w_mask_base;
        if (valid_i) begin
            w_mask_nxt[idx_i] = 1'b1;
            if (!w_mask_base[idx_i]) begin
                w_load = (w_mask_base == '0) || (data_i > w_max_base) ||
                         ((data_i == w_max_base) && (idx_i < w_idx_base));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask <= '0;
            r_max  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_full <= &w_mask_nxt;
            r_max  <= w_load ? data_i : w_max_base;
            r_idx  <= w_load ? idx_i  : w_idx_base;
        end
    end

    assign max_idx_o = r_idx;
    assign full_o    = r_full;
endmodule

// File: rtl/infer_monitor.sv
// Passive monitor scoring an inference program from its memory traffic.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   dmem_*_i           : snooped data-memory bus (observed only)
//   done_o             : all tests committed
//   test_cnt_o         : tests committed
//   correct_cnt_o      : correct predictions
//   pred_o             : last committed argmax
//   pred_valid_o       : one-cycle pulse, the cycle after a commit write
//   cycle_o            : active cycles from reset release to done (saturating)
//   err_o              : sticky incomplete-test / misplaced-commit flag
module infer_monitor
    import infer_mon_pkg::*;
#(
    parameter int unsigned         DWidth     = 32,
    parameter int unsigned         NumClasses = 10,
    parameter int unsigned         NumTests   = 100,
    parameter logic [ADDR_W-1:0]   OutputAddr = OUTPUT_ADDR_DEF,
    parameter logic [ADDR_W-1:0]   LabelAddr  = LABEL_ADDR_DEF,
    parameter logic [ADDR_W-1:0]   DoneAddr   = DONE_ADDR_DEF,
    localparam int unsigned        IdxW       = $clog2(NumClasses),
    localparam int unsigned        CntW       = $clog2(NumTests + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    input  logic              dmem_write_i,
    input  logic [DWidth-1:0] dmem_addr_i,
    input  logic [DWidth-1:0] dmem_wdata_i,
    input  logic [DWidth-1:0] dmem_rdata_i,
    output logic              done_o,
    output logic [CntW-1:0]   test_cnt_o,
    output logic [CntW-1:0]   correct_cnt_o,
    output logic [IdxW-1:0]   pred_o,
    output logic              pred_valid_o,
    output logic [63:0]       cycle_o,
    output logic              err_o
);
    localparam logic [DWidth-1:0] OutBase = DWidth'(OutputAddr);
    localparam logic [DWidth-1:0] OutSpan = DWidth'(4 * NumClasses);
    localparam logic [DWidth-1:0] LblBase = DWidth'(LabelAddr);
    localparam logic [DWidth-1:0] LblSpan = DWidth'(4 * NumTests);
    localparam logic [DWidth-1:0] DoneBase = DWidth'(DoneAddr);

    state_e            r_state, w_state_nxt;
    logic [CntW-1:0]   r_test_cnt, r_correct_cnt;
    logic [IdxW-1:0]   r_pred, r_label;
    logic              r_pred_valid, r_err, r_label_valid;
    logic [63:0]       r_cycle;

    logic              w_hs, w_active;
    logic [DWidth-1:0] w_out_off, w_lbl_off;
    logic              w_out_hit, w_lbl_hit, w_done_hit;
    logic [IdxW-1:0]   w_idx, w_max_idx;
    logic              w_full;
    logic              w_am_valid, w_lbl_take, w_clear, w_commit, w_commit_ign;

    // Address decode; byte offset bits are dropped by the shift.
    always_comb begin
        w_hs       = dmem_req_i && dmem_ready_i;
        w_active   = (r_state == COLLECT) || (r_state == COMMIT);
        w_out_off  = dmem_addr_i - OutBase;
        w_lbl_off  = dmem_addr_i - LblBase;
        w_out_hit  = dmem_write_i && (dmem_addr_i >= OutBase) && (w_out_off < OutSpan);
        w_lbl_hit  = !dmem_write_i && (dmem_addr_i >= LblBase) && (w_lbl_off < LblSpan);
        w_done_hit = dmem_write_i && (dmem_addr_i == DoneBase);
        w_idx      = IdxW'(w_out_off >> 2);
    end

    // Next state and per-cycle strobes; bus traffic is dead in IDLE/DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_am_valid   = 1'b0;
        w_lbl_take   = 1'b0;
        w_clear      = 1'b0;
        w_commit     = 1'b0;
        w_commit_ign = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = COLLECT;
            COLLECT: begin
                w_am_valid = w_hs && w_out_hit;
                w_lbl_take = w_hs && w_lbl_hit;
                w_commit   = w_hs && w_done_hit;
                if (w_commit) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                w_clear      = 1'b1;
                w_am_valid   = w_hs && w_out_hit;
                w_lbl_take   = w_hs && w_lbl_hit;
                w_commit_ign = w_hs && w_done_hit;
                w_state_nxt  = (r_test_cnt == CntW'(NumTests)) ? DONE : COLLECT;
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    infer_argmax #(
        .DWidth     (DWidth),
        .NumClasses (NumClasses)
    ) u_argmax (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (w_am_valid),
        .idx_i     (w_idx),
        .data_i    ($signed(dmem_wdata_i)),
        .clear_i   (w_clear),
        .max_idx_o (w_max_idx),
        .full_o    (w_full)
    );

    // Scoring is sampled at the commit handshake so results show in the COMMIT cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_test_cnt    <= '0;
            r_correct_cnt <= '0;
            r_pred        <= '0;
            r_pred_valid  <= 1'b0;
            r_cycle       <= '0;
            r_err         <= 1'b0;
            r_label       <= '0;
            r_label_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred_valid <= w_commit;
            if (w_commit) begin
                r_test_cnt <= r_test_cnt + CntW'(1);
                r_pred     <= w_max_idx;
                if (w_full && r_label_valid) begin
                    if (w_max_idx == r_label) r_correct_cnt <= r_correct_cnt + CntW'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_commit_ign) r_err <= 1'b1;
            if (w_lbl_take) begin
                r_label       <= IdxW'(dmem_rdata_i);
                r_label_valid <= 1'b1;
            end else if (w_clear) begin
                r_label_valid <= 1'b0;
            end
            if (w_active && (r_cycle != '1)) r_cycle <= r_cycle + 64'd1;
        end
    end

    assign done_o        = (r_state == DONE);
    assign test_cnt_o    = r_test_cnt;
    assign correct_cnt_o = r_correct_cnt;
    assign pred_o        = r_pred;
    assign pred_valid_o  = r_pred_valid;
    assign cycle_o       = r_cycle;
    assign err_o         = r_err;
endmodule

// File: doc/infer_monitor.md
INFER_MONITOR -- requirements
Module: infer_monitor

Interface
REQ-001 SHALL have parameters: DWidth, default 32, bus width; NumClasses, default 10, output-vector length; NumTests, default 100, tests before done; OutputAddr, default 32'h0000_0100, base of output vector (word-aligned); LabelAddr, default 32'h0000_0200, base of label region; DoneAddr, default 32'h0000_0300, per-test commit mailbox.
REQ-002 SHALL have ports, clock and reset first; one clock; reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dmem_req_i  in  1  snooped request
- dmem_ready_i  in  1  snooped ready
- dmem_write_i  in  1  1=write
- dmem_addr_i  in  DWidth  byte address
- dmem_wdata_i  in  DWidth  write data
- dmem_rdata_i  in  DWidth  read data, valid in handshake cycle
- done_o  out  1  all tests committed
- test_cnt_o  out  $clog2(NumTests+1)  tests committed
- correct_cnt_o  out  $clog2(NumTests+1)  correct predictions
- pred_o  out  $clog2(NumClasses)  last committed argmax
- pred_valid_o  out  1  one-cycle pulse per commit
- cycle_o  out  64  cycles from reset release to done
- err_o  out  1  sticky incomplete-test flag
REQ-003 SHALL be passive: it drives nothing on the snooped bus.

Function
REQ-004 SHALL treat a transaction as complete only in a cycle with dmem_req_i&&dmem_ready_i; all snooping is qualified by this.
REQ-005 SHALL decode an output write when write=1 and OutputAddr <= addr < OutputAddr+4*NumClasses; idx=(addr-OutputAddr)>>2; addr[1:0] ignored.
REQ-006 SHALL keep a running argmax: wdata compared as signed; replace when greater, or equal with lower idx; first write of a test always loads; set mask bit idx.
REQ-007 SHALL rewrite of an already-written idx update the mask only, without lowering the stored max (monotone rule).
REQ-008 SHALL decode a label read when write=0 and LabelAddr <= addr < LabelAddr+4*NumTests; capture rdata[$clog2(NumClasses)-1:0], set label_valid; a later label read overwrites it.
REQ-009 SHALL commit on any completed write with addr==DoneAddr.
REQ-010 SHALL use FSM states IDLE, COLLECT, COMMIT, DONE: IDLE->COLLECT after reset release; COLLECT->COMMIT on commit write; COMMIT->COLLECT, or ->DONE when the incremented test_cnt==NumTests; DONE is terminal until reset.
REQ-011 SHALL in COMMIT (one cycle): increment test_cnt; if mask full and label_valid, increment correct_cnt when argmax==label, else set err_o without incrementing correct; load pred_o; pulse pred_valid_o; clear mask, max and label_valid.
REQ-012 SHALL apply an output write or label read arriving in the COMMIT cycle to the next test, after clearing.
REQ-013 SHALL ignore a commit write arriving in the COMMIT cycle and set err_o.
REQ-014 SHALL ignore all bus activity in IDLE and DONE.
REQ-015 SHALL increment cycle_o every cycle in COLLECT/COMMIT, freeze it on entry to DONE, and saturate it at all-ones.
REQ-016 SHALL assert done_o combinationally from state==DONE.
REQ-017 SHALL have commit latency of 1 cycle: pred_valid_o is high the cycle after the commit handshake.

Reset
REQ-018 SHALL on rst_i: state IDLE; all counters, cycle_o, pred_o, mask, max, label_valid, err_o zero; pred_valid_o and done_o low.
REQ-019 SHALL let reset asserted mid-test or in DONE discard all partial state; the first post-reset cycle is IDLE.

Structure
REQ-020 SHALL put the state enum and default address constants in package infer_mon_pkg.
REQ-021 SHALL put argmax, mask and clear logic in sub-module infer_argmax (inputs: valid, idx, data, clear; outputs: max_idx, full).
REQ-022 SHALL keep counters and FSM in infer_monitor; total RTL 120-400 lines.

Verification (NumClasses=10, NumTests=3, default addresses)
REQ-023 SHALL cover: writes 0..9 to 0x100..0x124 with class 7 max=500, label read rdata=7, write 0x300 -> pred_o=7, pred_valid_o pulse, correct_cnt=1, test_cnt=1.
REQ-024 SHALL cover: values tie at idx 2 and 5 (=300), label 5, commit -> pred_o=2, correct_cnt unchanged.
REQ-025 SHALL cover: only 9 classes written, commit -> err_o=1, test_cnt increments, correct_cnt unchanged.
REQ-026 SHALL cover: three full commits -> done_o=1 the cycle after the third pred_valid_o; cycle_o frozen; later bus writes change nothing.
REQ-027 SHALL cover: req=1, ready=0 writes to 0x100 and 0x300 held 5 cycles -> no mask or count change.
REQ-028 SHALL cover: rst_i pulsed after 4 output writes -> all outputs zero; a fresh complete test then scores correctly.
